// File: rtl/key_deb_multi.sv
// key_deb_multi: multi-channel key debouncer and event generator.
// Each channel synchronises its raw key pin, debounces press and release
// symmetrically, and produces a stable level plus one-cycle press, release,
// long-press and (optional) auto-repeat pulses.
// Optional feature macro: KEY_DEB_REPEAT_EN enables the auto-repeat pulse
// generator. When it is undefined, repeat_pulse is tied to 0.
module key_deb_multi #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned DEB_CNT    = 1_000_000,
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned REP_CNT    = 10_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  localparam int unsigned MAX_DL  = (DEB_CNT > LONG_CNT) ? DEB_CNT : LONG_CNT;
  localparam int unsigned MAX_CNT = (MAX_DL > REP_CNT) ? MAX_DL : REP_CNT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CNT);
`ifdef KEY_DEB_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 1);
`endif

  // Pin level of a released key; synchroniser resets to this.
  localparam logic INACT = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_DEB   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_DEB = 2'd3
  } state_t;

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
    logic [1:0]       sync_q;
    logic             act;
    state_t           state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             state_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             repeat_q;
`ifdef KEY_DEB_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
`endif

    // Two-flop synchroniser for the asynchronous key pin.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_q <= {2{INACT}};
      end else begin
        sync_q <= {sync_q[0], key_in[g]};
      end
    end

    // Normalise polarity: act = 1 means the key is pressed.
    assign act = sync_q[1] ^ INACT;

    // Debounce FSM with hold/repeat counters and registered event outputs.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state     <= S_IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
`ifdef KEY_DEB_REPEAT_EN
        rep_cnt   <= '0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          S_IDLE: begin
            deb_cnt <= '0;
            if (act) begin
              state <= S_PRESS_DEB;
            end
          end
          S_PRESS_DEB: begin
            if (!act) begin
              state   <= S_IDLE;
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state    <= S_HELD;
              state_q  <= 1'b1;
              press_q  <= 1'b1;
              hold_cnt <= '0;
`ifdef KEY_DEB_REPEAT_EN
              rep_cnt  <= '0;
`endif
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end
          S_HELD: begin
            if (hold_cnt != LONG_SAT) begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
            // Saturation guarantees this matches once per press.
            if (hold_cnt == LONG_LAST) begin
              long_q <= 1'b1;
            end
`ifdef KEY_DEB_REPEAT_EN
            // Repeat phase starts only after the long pulse has fired.
            if (hold_cnt == LONG_SAT) begin
              if (rep_cnt == REP_LAST) begin
                rep_cnt  <= '0;
                repeat_q <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + CNT_W'(1);
              end
            end
`endif
            if (!act) begin
              state   <= S_RELEASE_DEB;
              deb_cnt <= '0;
            end
          end
          S_RELEASE_DEB: begin
            // Glitch back to active: resume the hold without re-reporting.
            if (act) begin
              state <= S_HELD;
            end else if (deb_cnt == DEB_LAST) begin
              state     <= S_IDLE;
              state_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end
          default: begin
            state   <= S_IDLE;
            deb_cnt <= '0;
          end
        endcase
      end
    end

    assign key_state[g]     = state_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign long_pulse[g]    = long_q;
`ifdef KEY_DEB_REPEAT_EN
    assign repeat_pulse[g]  = repeat_q;
`else
    assign repeat_pulse[g]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_deb_multi.sv
// Self-checking bench for key_deb_multi (N_KEYS=2, active-low keys,
// DEB_CNT=4, LONG_CNT=16, REP_CNT=8). A sample-run model predicts every
// output each cycle; directed literal checks pin the model's timing.
module tb_key_deb_multi;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int REP  = 8;

  logic       clk;
  logic       rstn;
  logic [1:0] key_in;
  logic [1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int n_checks = 0;
  int n_errors = 0;

  key_deb_multi #(
    .N_KEYS(2), .ACTIVE_LOW(1), .DEB_CNT(DEB), .LONG_CNT(LONG), .REP_CNT(REP)
  ) dut (
    .clk(clk), .rstn(rstn), .key_in(key_in),
    .key_state(key_state), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: debounced level flips after DEB+1 consecutive synchronised
  // samples disagreeing with it; hold time counts cycles spent settled in
  // the pressed level.
  logic [1:0] h1 = 2'b11, h2 = 2'b11, lvl = 2'b00;
  logic [1:0] m_press = 2'b00, m_rel = 2'b00, m_long = 2'b00, m_rep = 2'b00;
  int run [2] = '{0, 0};
  int held [2] = '{0, 0};
  logic a, wh;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h1 = 2'b11; h2 = 2'b11; lvl = 2'b00;
      m_press = 2'b00; m_rel = 2'b00; m_long = 2'b00; m_rep = 2'b00;
      for (int k = 0; k < 2; k++) begin
        run[k] = 0;
        held[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a  = (h2[k] == 1'b0);
        wh = lvl[k] && (run[k] == 0);
        m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0; m_rep[k] = 1'b0;
        if (wh) begin
          held[k]++;
          if (held[k] == LONG) m_long[k] = 1'b1;
`ifdef KEY_DEB_REPEAT_EN
          if (held[k] > LONG && ((held[k] - LONG) % REP) == 0) m_rep[k] = 1'b1;
`endif
        end
        if (a != lvl[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DEB + 1) begin
          lvl[k] = ~lvl[k];
          run[k] = 0;
          if (lvl[k]) begin
            m_press[k] = 1'b1;
            held[k] = 0;
          end else begin
            m_rel[k] = 1'b1;
          end
        end
      end
      h2 = h1;
      h1 = key_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #1;
    chk("key_state",     32'(key_state),     32'(lvl));
    chk("press_pulse",   32'(press_pulse),   32'(m_press));
    chk("release_pulse", 32'(release_pulse), 32'(m_rel));
    chk("long_pulse",    32'(long_pulse),    32'(m_long));
    chk("repeat_pulse",  32'(repeat_pulse),  32'(m_rep));
  end

  // Event monitor: pulse counts and cycle stamps from the DUT outputs.
  int cyc = 0;
  int n_press0 = 0, n_rel0 = 0, n_press1 = 0, n_long1 = 0, n_rep1 = 0;
  int p_cyc1 = 0, l_cyc1 = 0;
  int rep_q [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (press_pulse[0])   n_press0++;
    if (release_pulse[0]) n_rel0++;
    if (press_pulse[1])  begin n_press1++; p_cyc1 = cyc; end
    if (long_pulse[1])   begin n_long1++;  l_cyc1 = cyc; end
    if (repeat_pulse[1]) begin n_rep1++;   rep_q.push_back(cyc); end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn   = 1'b0;
    key_in = 2'b10;
    tick(3);
    // Reset state with key0 already pressed.
    chk("rst_key_state", 32'(key_state), 32'd0);
    chk("rst_press",     32'(press_pulse), 32'd0);
    chk("rst_release",   32'(release_pulse), 32'd0);
    chk("rst_long",      32'(long_pulse), 32'd0);
    chk("rst_repeat",    32'(repeat_pulse), 32'd0);
    rstn = 1'b1;
    tick(6);
    chk("post_rst_press_e6", 32'(press_pulse[0]), 32'd0);
    tick(1);
    chk("post_rst_press_e7", 32'(press_pulse[0]), 32'd1);
    chk("post_rst_state_e7", 32'(key_state[0]), 32'd1);
    key_in[0] = 1'b1;
    tick(6);
    chk("rel_e6", 32'(release_pulse[0]), 32'd0);
    tick(1);
    chk("rel_e7", 32'(release_pulse[0]), 32'd1);
    chk("rel_state_e7", 32'(key_state[0]), 32'd0);

    // Clean press held 20 cycles.
    tick(3);
    n_press0 = 0; n_rel0 = 0;
    key_in[0] = 1'b0;
    tick(6);
    chk("clean_press_e6", 32'(press_pulse[0]), 32'd0);
    tick(1);
    chk("clean_press_e7", 32'(press_pulse[0]), 32'd1);
    chk("clean_state", 32'(key_state[0]), 32'd1);
    tick(13);
    key_in[0] = 1'b1;
    tick(6);
    chk("clean_rel_e6", 32'(release_pulse[0]), 32'd0);
    tick(1);
    chk("clean_rel_e7", 32'(release_pulse[0]), 32'd1);
    tick(10);
    chk("clean_n_press", 32'(n_press0), 32'd1);
    chk("clean_n_rel",   32'(n_rel0),   32'd1);

    // Bounce: 2-cycle toggles never complete a window.
    n_press0 = 0; n_rel0 = 0;
    for (int i = 0; i < 5; i++) begin
      key_in[0] = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick(2);
    end
    key_in[0] = 1'b1;
    tick(15);
    chk("bounce_n_press", 32'(n_press0), 32'd0);
    chk("bounce_n_rel",   32'(n_rel0),   32'd0);
    chk("bounce_state",   32'(key_state[0]), 32'd0);

    // One-cycle release glitch while held.
    key_in[0] = 1'b0;
    tick(12);
    chk("glitch_pre_state", 32'(key_state[0]), 32'd1);
    n_rel0 = 0;
    key_in[0] = 1'b1;
    tick(1);
    key_in[0] = 1'b0;
    tick(15);
    chk("glitch_n_rel", 32'(n_rel0), 32'd0);
    chk("glitch_state", 32'(key_state[0]), 32'd1);
    key_in[0] = 1'b1;
    tick(10);
    chk("glitch_final_rel", 32'(n_rel0), 32'd1);
    chk("glitch_final_state", 32'(key_state[0]), 32'd0);

    // Long press and repeat on key1.
    n_press1 = 0; n_long1 = 0; n_rep1 = 0;
    rep_q.delete();
    key_in[1] = 1'b0;
    tick(60);
    key_in[1] = 1'b1;
    tick(12);
    chk("long_n_press", 32'(n_press1), 32'd1);
    chk("long_n_long",  32'(n_long1),  32'd1);
    chk("long_offset",  32'(l_cyc1 - p_cyc1), 32'd16);
`ifdef KEY_DEB_REPEAT_EN
    chk("rep_at_least_3", 32'(rep_q.size() >= 3), 32'd1);
    if (rep_q.size() >= 3) begin
      chk("rep_off1", 32'(rep_q[0] - l_cyc1), 32'd8);
      chk("rep_off2", 32'(rep_q[1] - l_cyc1), 32'd16);
      chk("rep_off3", 32'(rep_q[2] - l_cyc1), 32'd24);
    end
`else
    chk("rep_disabled", 32'(n_rep1), 32'd0);
`endif

    // Simultaneous press on both keys.
    key_in = 2'b00;
    tick(6);
    chk("simul_e6", 32'(press_pulse), 32'd0);
    tick(1);
    chk("simul_e7", 32'(press_pulse), 32'd3);
    tick(3);
    key_in = 2'b11;
    tick(12);
    chk("simul_released", 32'(key_state), 32'd0);

    // Reset in the middle of a press window.
    key_in[0] = 1'b0;
    tick(3);
    rstn = 1'b0;
    tick(2);
    chk("midrst_state", 32'(key_state), 32'd0);
    chk("midrst_press", 32'(press_pulse), 32'd0);
    chk("midrst_rel",   32'(release_pulse), 32'd0);
    n_press0 = 0;
    rstn = 1'b1;
    tick(6);
    chk("midrst_press_e6", 32'(press_pulse[0]), 32'd0);
    chk("midrst_n_press",  32'(n_press0), 32'd0);
    tick(1);
    chk("midrst_press_e7", 32'(press_pulse[0]), 32'd1);
    key_in = 2'b11;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
